// File: rtl/wb_arbiter2_pkg.sv
// wb_arbiter2_pkg: shared arbiter state type and default bus timeout
package wb_arbiter2_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS0  = 2'd1,
        BUS1  = 2'd2,
        ABORT = 2'd3
    } wb_arb_state_t;
    localparam int WB_ARB_TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/wb_arb_timeout.sv
// wb_arb_timeout: saturating stall counter flagging when TIMEOUT is reached (0 disables)
module wb_arb_timeout
    import wb_arbiter2_pkg::*;
#(
    parameter int TIMEOUT = WB_ARB_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] MAX = CW'(TIMEOUT);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en && cnt != MAX) cnt <= cnt + CW'(1);
    end
    assign hit = (TIMEOUT != 0) && (cnt == MAX);
endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone classic arbiter, round-robin per cyc envelope with stall timeout
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = WB_ARB_TIMEOUT_DEFAULT
) (
    input  logic                clock_main,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   m0_adr_i,
    input  logic [DATA_W-1:0]   m0_dat_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    input  logic                m0_we_i,
    input  logic                m0_stb_i,
    input  logic                m0_cyc_i,
    output logic [DATA_W-1:0]   m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    input  logic [ADDR_W-1:0]   m1_adr_i,
    input  logic [DATA_W-1:0]   m1_dat_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    input  logic                m1_we_i,
    input  logic                m1_stb_i,
    input  logic                m1_cyc_i,
    output logic [DATA_W-1:0]   m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic [ADDR_W-1:0]   s_adr_o,
    output logic [DATA_W-1:0]   s_dat_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    output logic                s_we_o,
    output logic                s_stb_o,
    output logic                s_cyc_o,
    input  logic [DATA_W-1:0]   s_dat_i,
    input  logic                s_ack_i,
    output logic [1:0]          grant_o,
    output logic                timeout_o
);
    wb_arb_state_t state, state_nx;
    logic last_grant, abort_m, bus0, bus1, hit, tmo;

    assign bus0 = state == BUS0;
    assign bus1 = state == BUS1;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = (m0_cyc_i && m1_cyc_i) ? (last_grant ? BUS0 : BUS1) :
                                m0_cyc_i ? BUS0 : m1_cyc_i ? BUS1 : IDLE;
            BUS0:    state_nx = tmo ? ABORT : m0_cyc_i ? BUS0 : m1_cyc_i ? BUS1 : IDLE;
            BUS1:    state_nx = tmo ? ABORT : m1_cyc_i ? BUS1 : m0_cyc_i ? BUS0 : IDLE;
            default: state_nx = (abort_m ? m1_cyc_i : m0_cyc_i) ? ABORT : IDLE;
        endcase
    end

    // abort_m remembers whose cyc must drop before ABORT may release the bus
    always_ff @(posedge clock_main) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            abort_m    <= 1'b0;
        end else begin
            state      <= state_nx;
            last_grant <= (state_nx != state && (state_nx == BUS0 || state_nx == BUS1)) ?
                          state_nx == BUS1 : last_grant;
            abort_m    <= tmo ? bus1 : abort_m;
        end
    end

    assign s_cyc_o = bus0 ? m0_cyc_i : bus1 ? m1_cyc_i : 1'b0;
    assign s_stb_o = bus0 ? m0_stb_i : bus1 ? m1_stb_i : 1'b0;
    assign s_we_o  = bus0 ? m0_we_i  : bus1 ? m1_we_i  : 1'b0;
    assign s_sel_o = bus0 ? m0_sel_i : bus1 ? m1_sel_i : '0;
    assign s_adr_o = bus0 ? m0_adr_i : bus1 ? m1_adr_i : '0;
    assign s_dat_o = bus0 ? m0_dat_i : bus1 ? m1_dat_i : '0;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & bus0 & m0_stb_i;
    assign m1_ack_o = s_ack_i & bus1 & m1_stb_i;

    wb_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk (clock_main),
        .rst (rst),
        .clr (s_ack_i || !s_stb_o || state_nx != state),
        .en  ((bus0 || bus1) && s_stb_o && !s_ack_i),
        .hit (hit)
    );

    // an ack landing on the limit cycle completes the transfer instead of aborting
    assign tmo       = hit & (bus0 | bus1) & s_stb_o & ~s_ack_i;
    assign m0_err_o  = tmo & bus0;
    assign m1_err_o  = tmo & bus1;
    assign timeout_o = tmo;
    assign grant_o   = {bus1, bus0};
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: randomized scoreboard bench for wb_arbiter2 against a transaction-level model
module tb_wb_arbiter2;
    localparam int TMO = 4, NEVER = 1000;

    typedef struct {
        int          m;
        bit          err;
        logic [31:0] rdat, adr, wdat;
        logic [3:0]  sel;
        bit          we;
    } exp_t;

    logic clock_main = 1'b0, rst = 1'b1;
    always #5 clock_main = ~clock_main;

    logic [31:0] adr [2], dat [2];
    logic [3:0]  sel [2];
    logic        we [2], stb [2], cyc [2];
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_we_o, s_stb_o, s_cyc_o, s_ack_i, timeout_o;
    logic [1:0]  grant_o;

    exp_t        sb [$];
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] st_adr [2][3], st_dat [2][3];
    logic [3:0]  st_sel [2][3];
    bit          st_we [2][3];
    int          st_n [2];
    int          slave_wait = 0, ws = 0, last_g = 1, seq = 0, stall = 0;
    bit          ack_force = 0, log_en = 0, err_prev = 0;
    logic [1:0]  prev_g = 2'b00;

    wb_arbiter2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clock_main(clock_main), .rst(rst),
        .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_sel_i(sel[0]), .m0_we_i(we[0]),
        .m0_stb_i(stb[0]), .m0_cyc_i(cyc[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_sel_i(sel[1]), .m1_we_i(we[1]),
        .m1_stb_i(stb[1]), .m1_cyc_i(cyc[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    function automatic logic [31:0] rdata(input logic [31:0] a);
        return a == 32'h0300_0010 ? 32'hDEAD_BEEF : a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic int oh(input int m);
        return m == 1 ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_grant"}, grant_o, 0);
        chk({tag, "_s_ctrl"}, {s_cyc_o, s_stb_o, s_we_o, s_sel_o}, 0);
        chk({tag, "_s_adr"}, s_adr_o, 0);
        chk({tag, "_s_dat"}, s_dat_o, 0);
        chk({tag, "_resp"}, {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o}, 0);
    endtask

    // slave: acks each strobe after slave_wait stalled cycles, read data derived from address
    initial begin
        s_ack_i = 1'b0;
        s_dat_i = '0;
        forever begin
            @(posedge clock_main);
            #2;
            if (s_ack_i) begin
                s_ack_i = 1'b0;
                ws = 0;
                s_dat_i = $urandom;
            end else if (s_stb_o) begin
                if (ws >= slave_wait) begin
                    s_ack_i = 1'b1;
                    s_dat_i = rdata(s_adr_o);
                end else ws++;
            end else ws = 0;
            if (ack_force) s_ack_i = 1'b1;
        end
    end

    // monitor: pops the scoreboard on every ack/err presented to a master
    initial begin
        int m;
        bit e;
        exp_t x;
        forever begin
            @(negedge clock_main);
            stall = (s_stb_o && !s_ack_i) ? stall + 1 : 0;
            if (err_prev) chk("cyc_drop_after_err", s_cyc_o, 0);
            err_prev = m0_err_o | m1_err_o;
            if (log_en && grant_o != prev_g) begin
                seq = (seq << 2) | int'(grant_o);
                prev_g = grant_o;
            end
            if (m0_ack_o | m1_ack_o | m0_err_o | m1_err_o) begin
                m = (m1_ack_o | m1_err_o) ? 1 : 0;
                e = m0_err_o | m1_err_o;
                chk("one_master", (m0_ack_o | m0_err_o) & (m1_ack_o | m1_err_o), 0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: master %0d err %0b presented with nothing expected", m, e);
                end else begin
                    x = sb.pop_front();
                    chk("master", m, x.m);
                    chk("err", e, x.err);
                    chk("grant", grant_o, oh(m));
                    if (x.err) begin
                        chk("timeout_o", timeout_o, 1);
                        chk("stall_cycles", stall, TMO + 1);
                        chk("s_cyc_in_err", s_cyc_o, 1);
                    end else begin
                        chk("rdata", m == 1 ? m1_dat_o : m0_dat_o, x.rdat);
                        chk("s_adr", s_adr_o, x.adr);
                        chk("s_we", s_we_o, x.we);
                        chk("s_sel", s_sel_o, x.sel);
                        if (x.we) chk("s_dat", s_dat_o, x.wdat);
                        chk("timeout_quiet", timeout_o, 0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic master_run(input int m);
        int got;
        @(posedge clock_main);
        #1;
        cyc[m] = 1'b1;
        for (int k = 0; k < st_n[m]; k++) begin
            adr[m] = st_adr[m][k];
            dat[m] = st_dat[m][k];
            sel[m] = st_sel[m][k];
            we[m]  = st_we[m][k];
            stb[m] = 1'b1;
            got = 0;
            for (int t = 0; t < 80 && got == 0; t++) begin
                @(negedge clock_main);
                got = (m == 1 ? m1_ack_o : m0_ack_o) ? 1 : (m == 1 ? m1_err_o : m0_err_o) ? 2 : 0;
            end
            if (got == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL master%0d_wait: no ack or err within 80 cycles", m);
            end
            @(posedge clock_main);
            #1;
            stb[m] = 1'b0;
            we[m]  = 1'b0;
            if (got != 1) break;
        end
        cyc[m] = 1'b0;
    endtask

    task automatic push(input int m, input bit stalled);
        exp_t x;
        x.m = m;
        x.err = stalled;
        if (stalled) begin
            x.rdat = '0; x.adr = '0; x.wdat = '0; x.sel = '0; x.we = 1'b0;
            sb.push_back(x);
        end else begin
            for (int k = 0; k < st_n[m]; k++) begin
                x.adr  = st_adr[m][k];
                x.rdat = rdata(st_adr[m][k]);
                x.wdat = st_dat[m][k];
                x.sel  = st_sel[m][k];
                x.we   = st_we[m][k];
                sb.push_back(x);
            end
        end
    endtask

    task automatic rand_strobes(input int m);
        st_n[m] = $urandom_range(1, 3);
        for (int k = 0; k < 3; k++) begin
            st_adr[m][k] = 32'h0300_0000 | ($urandom & 32'h00FF_FFFC);
            st_dat[m][k] = $urandom;
            st_sel[m][k] = 4'($urandom_range(1, 15));
            st_we[m][k]  = 1'($urandom);
        end
    endtask

    // model: grants alternate on ties, a slave stalling longer than TMO cycles yields one error per master
    task automatic run_round(input bit r0, input bit r1, input int w, input bit m1_first);
        int f, s, eseq;
        bit stalled;
        f = (r0 && r1) ? (m1_first ? 1 : (last_g == 1 ? 0 : 1)) : (r0 ? 0 : 1);
        s = 1 - f;
        stalled = w > TMO;
        push(f, stalled);
        if (r0 && r1) push(s, stalled);
        last_g = (r0 && r1) ? s : f;
        eseq = !(r0 && r1) ? oh(f) << 2 : stalled ? (oh(f) << 6) | (oh(s) << 2) : (oh(f) << 4) | (oh(s) << 2);
        slave_wait = w;
        seq = 0;
        prev_g = 2'b00;
        log_en = 1'b1;
        fork
            if (r0) begin
                if (m1_first && r1) @(posedge clock_main);
                master_run(0);
            end
            if (r1) master_run(1);
            begin
                @(posedge clock_main);
                @(negedge clock_main);
                chk("arb_latency_pre", s_cyc_o, 0);
                @(negedge clock_main);
                chk("arb_latency", s_cyc_o, 1);
            end
        join
        repeat (3) @(posedge clock_main);
        log_en = 1'b0;
        chk("grant_seq", seq, eseq);
    endtask

    initial begin
        int r;
        for (int i = 0; i < 2; i++) begin
            adr[i] = '0; dat[i] = '0; sel[i] = '0; we[i] = 1'b0; stb[i] = 1'b0; cyc[i] = 1'b0;
        end
        repeat (3) @(posedge clock_main);
        @(negedge clock_main);
        idle_check("reset");
        @(posedge clock_main);
        #1 rst = 1'b0;

        // ties straight out of reset: m0 first, then alternate
        for (int i = 0; i < 2; i++) begin
            rand_strobes(0);
            rand_strobes(1);
            run_round(1'b1, 1'b1, $urandom_range(0, 2), 1'b0);
        end

        st_n[0] = 1;
        st_adr[0][0] = 32'h0300_0010;
        st_we[0][0] = 1'b0;
        st_sel[0][0] = 4'hF;
        st_dat[0][0] = '0;
        run_round(1'b1, 1'b0, 2, 1'b0);

        // locked read-modify-write by m1 with m0 queued behind it
        rand_strobes(0);
        st_n[1] = 2;
        st_adr[1][0] = 32'h0300_0200; st_we[1][0] = 1'b0; st_sel[1][0] = 4'hF;   st_dat[1][0] = '0;
        st_adr[1][1] = 32'h0300_0200; st_we[1][1] = 1'b1; st_sel[1][1] = 4'b0011; st_dat[1][1] = 32'hCAFE_0042;
        run_round(1'b1, 1'b1, 1, 1'b1);

        rand_strobes(0);
        run_round(1'b1, 1'b0, NEVER, 1'b0);

        rand_strobes(0);
        st_n[0] = 1;
        run_round(1'b1, 1'b0, TMO, 1'b0);

        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(1, 3);
            rand_strobes(0);
            rand_strobes(1);
            run_round(r[0], r[1], ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, 2), 1'b0);
        end

        // reset in the middle of a granted m1 write, then a stray ack
        slave_wait = NEVER;
        @(posedge clock_main);
        #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
        adr[1] = 32'h0300_0100; dat[1] = 32'h1234_5678; sel[1] = 4'hF;
        @(negedge clock_main);
        @(negedge clock_main);
        chk("rst_pre_grant", grant_o, 2);
        chk("rst_pre_we", s_we_o, 1);
        @(posedge clock_main);
        #1 rst = 1'b1;
        @(posedge clock_main);
        #1 ack_force = 1'b1;
        @(negedge clock_main);
        idle_check("mid_reset");
        @(posedge clock_main);
        #1;
        rst = 1'b0; ack_force = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        last_g = 1;
        repeat (2) @(posedge clock_main);
        @(negedge clock_main);
        idle_check("post_reset");

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
